// File: rtl/goertzel_tone_detector.sv
// Single-bin Goertzel power detector: runs the s0 = x + c*s1 - s2 recurrence over
// a block of N samples and reports s1^2 + s2^2 - c*s1*s2 through a valid/ready port.
module goertzel_tone_detector #(
  parameter int DW = 12,
  parameter int N  = 256,
  parameter int CW = 16,
  parameter int AW = 24,
  parameter int PW = 48
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [CW-1:0] coef,
  input  logic          samp_valid,
  input  logic [DW-1:0] samp_data,
  output logic          busy,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [PW-1:0] res_power,
  output logic          sat
);

  localparam int CNW = $clog2(N);
  localparam int FB  = 14;
  localparam int PRW = CW + AW;
  localparam int EW  = PRW + 2;
  localparam int TW  = CW + 2 * AW;

  typedef enum logic [2:0] {IDLE, ACCUM, CALC1, CALC2, HOLD} state_t;

  state_t               state_q, state_d;
  logic signed [CW-1:0] coef_q, coef_d;
  logic signed [AW-1:0] s1_q, s1_d, s2_q, s2_d;
  logic [CNW-1:0]       cnt_q, cnt_d;
  logic                 sat_q, sat_d;
  logic [PW-1:0]        sq1_q, sq1_d, sq2_q, sq2_d;
  logic signed [PW+1:0] t_q, t_d;
  logic [PW-1:0]        res_power_q, res_power_d;

  logic signed [PRW-1:0] fb_prod, fb_shift;
  logic signed [EW-1:0]  s0_wide;
  logic                  s0_ovf;
  logic signed [AW-1:0]  s0_sat;
  logic signed [PW-1:0]  s1_ext, s2_ext, sq1_full, sq2_full;
  logic signed [TW-1:0]  cross_prod;
  logic signed [PW+1:0]  p_wide;
  logic                  unused_lsbs;

  always_comb begin
    fb_prod  = $signed({{AW{coef_q[CW-1]}}, coef_q}) * $signed({{CW{s1_q[AW-1]}}, s1_q});
    fb_shift = fb_prod >>> FB;
    s0_wide  = $signed({{(EW-PRW){fb_shift[PRW-1]}}, fb_shift})
             + $signed({{(EW-DW){samp_data[DW-1]}}, samp_data})
             - $signed({{(EW-AW){s2_q[AW-1]}}, s2_q});
    // s0 fits in AW bits only when every bit from AW-1 upward matches the sign bit
    s0_ovf   = s0_wide[EW-1:AW-1] != {(EW-AW+1){s0_wide[EW-1]}};
    if (s0_ovf) begin
      s0_sat = s0_wide[EW-1] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end else begin
      s0_sat = s0_wide[AW-1:0];
    end

    s1_ext     = $signed({{(PW-AW){s1_q[AW-1]}}, s1_q});
    s2_ext     = $signed({{(PW-AW){s2_q[AW-1]}}, s2_q});
    sq1_full   = s1_ext * s1_ext;
    sq2_full   = s2_ext * s2_ext;
    cross_prod = $signed({{(TW-CW){coef_q[CW-1]}}, coef_q})
               * $signed({{(TW-AW){s1_q[AW-1]}}, s1_q})
               * $signed({{(TW-AW){s2_q[AW-1]}}, s2_q});
    unused_lsbs = ^cross_prod[FB-1:0];

    p_wide = $signed({2'b00, sq1_q}) + $signed({2'b00, sq2_q}) - t_q;
  end

  always_comb begin
    state_d     = state_q;
    coef_d      = coef_q;
    s1_d        = s1_q;
    s2_d        = s2_q;
    cnt_d       = cnt_q;
    sat_d       = sat_q;
    sq1_d       = sq1_q;
    sq2_d       = sq2_q;
    t_d         = t_q;
    res_power_d = res_power_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          coef_d  = coef;
          s1_d    = '0;
          s2_d    = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end
      end
      ACCUM: begin
        if (samp_valid) begin
          s2_d  = s1_q;
          s1_d  = s0_sat;
          cnt_d = cnt_q + CNW'(1);
          if (s0_ovf) sat_d = 1'b1;
          if (cnt_q == CNW'(N - 1)) state_d = CALC1;
        end
      end
      CALC1: begin
        sq1_d   = sq1_full;
        sq2_d   = sq2_full;
        t_d     = cross_prod[PW+1+FB:FB];
        state_d = CALC2;
      end
      CALC2: begin
        // Negative power is rounding noise; overflow past PW bits is flagged as saturation
        if (p_wide[PW+1]) begin
          res_power_d = '0;
        end else if (p_wide[PW]) begin
          res_power_d = '1;
          sat_d       = 1'b1;
        end else begin
          res_power_d = p_wide[PW-1:0];
        end
        state_d = HOLD;
      end
      HOLD: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      coef_q      <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      cnt_q       <= '0;
      sat_q       <= 1'b0;
      sq1_q       <= '0;
      sq2_q       <= '0;
      t_q         <= '0;
      res_power_q <= '0;
    end else begin
      state_q     <= state_d;
      coef_q      <= coef_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      cnt_q       <= cnt_d;
      sat_q       <= sat_d;
      sq1_q       <= sq1_d;
      sq2_q       <= sq2_d;
      t_q         <= t_d;
      res_power_q <= res_power_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign res_valid = (state_q == HOLD);
  assign res_power = res_power_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_goertzel_tone_detector.sv
// Directed bench for goertzel_tone_detector: table of hand-computed blocks plus
// reset, backpressure, gapped-input and back-to-back sequences.
module tb_goertzel_tone_detector;

  localparam int DW = 12;
  localparam int N  = 256;
  localparam int CW = 16;
  localparam int AW = 24;
  localparam int PW = 48;

  localparam int KIND_TONE    = 0;
  localparam int KIND_DC      = 1;
  localparam int KIND_IMPULSE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] coef;
  logic          samp_valid;
  logic [DW-1:0] samp_data;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [PW-1:0] res_power;
  logic          sat;

  int checks   = 0;
  int failures = 0;
  int edge_cnt = 0;

  typedef struct {
    logic [CW-1:0] coef;
    int            kind;
    int            amp;
    int            pos;
    logic [PW-1:0] exp_power;
    logic          chk_power;
    logic          exp_sat;
  } vec_t;

  vec_t vecs[8];

  goertzel_tone_detector #(.DW(DW), .N(N), .CW(CW), .AW(AW), .PW(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .coef       (coef),
    .samp_valid (samp_valid),
    .samp_data  (samp_data),
    .busy       (busy),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_power  (res_power),
    .sat        (sat)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    edge_cnt++;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int gen(input int kind, input int amp, input int pos, input int i);
    int v;
    v = 0;
    if (kind == KIND_TONE) begin
      if (i % 4 == 0) v = amp;
      else if (i % 4 == 2) v = -amp;
    end else if (kind == KIND_DC) begin
      v = amp;
    end else if (i == pos) begin
      v = amp;
    end
    return v;
  endfunction

  // Pulses start, feeds N samples (optionally one idle cycle after each) and waits for the result
  task automatic applyStimulus(input logic [CW-1:0] c, input int kind, input int amp, input int pos,
                               input int gap, input int start_at, output int lat);
    int e0;
    int guard;
    start = 1'b1;
    coef  = c;
    tick();
    e0    = edge_cnt;
    start = 1'b0;
    coef  = '0;
    checkOutput("busy_after_start", busy, 1);
    checkOutput("sat_cleared_on_start", sat, 0);
    for (int i = 0; i < N; i++) begin
      samp_valid = 1'b1;
      samp_data  = DW'(gen(kind, amp, pos, i));
      tick();
      if (gap != 0) begin
        samp_valid = 1'b0;
        samp_data  = DW'(1234);
        if (i == start_at) start = 1'b1;
        tick();
        start = 1'b0;
      end
    end
    samp_valid = 1'b0;
    samp_data  = '0;
    guard = 0;
    while (!res_valid && guard < 20) begin
      tick();
      guard++;
    end
    checkOutput("res_valid_within_bound", res_valid, 1);
    lat = edge_cnt - e0 + 1;
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    checkOutput("busy_after_handshake", busy, 0);
    checkOutput("res_valid_after_handshake", res_valid, 0);
  endtask

  initial begin
    int lat;
    logic [PW-1:0] held;

    vecs[0] = '{16'h0000, KIND_TONE,    100,  0, 48'd163840000, 1'b1, 1'b0};
    vecs[1] = '{16'h0000, KIND_DC,      100,  0, 48'd0,         1'b1, 1'b0};
    vecs[2] = '{16'h0000, KIND_IMPULSE, 1000, 0, 48'd1000000,   1'b1, 1'b0};
    vecs[3] = '{16'h4000, KIND_IMPULSE, 64,   2, 48'd4096,      1'b1, 1'b0};
    vecs[4] = '{16'hC000, KIND_IMPULSE, 64,   2, 48'd4096,      1'b1, 1'b0};
    vecs[5] = '{16'h0001, KIND_IMPULSE, -1,   4, 48'd2,         1'b1, 1'b0};
    vecs[6] = '{16'h7FFF, KIND_DC,      2047, 0, 48'd0,         1'b0, 1'b1};
    vecs[7] = '{16'h0000, KIND_TONE,    100,  0, 48'd163840000, 1'b1, 1'b0};

    rst        = 1'b1;
    start      = 1'b0;
    coef       = '0;
    samp_valid = 1'b0;
    samp_data  = '0;
    res_ready  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_res_valid", res_valid, 0);
    checkOutput("reset_res_power", res_power, 0);
    checkOutput("reset_sat", sat, 0);

    for (int v = 0; v < 8; v++) begin
      samp_valid = 1'b1;
      samp_data  = DW'(555);
      repeat (2) tick();
      samp_valid = 1'b0;
      checkOutput("idle_ignores_samples", busy, 0);
      applyStimulus(vecs[v].coef, vecs[v].kind, vecs[v].amp, vecs[v].pos, 0, -1, lat);
      checkOutput("latency_full_rate", lat, N + 3);
      if (vecs[v].chk_power) checkOutput("res_power", res_power, vecs[v].exp_power);
      checkOutput("sat_flag", sat, vecs[v].exp_sat);
      held = res_power;
      handshake();
      checkOutput("res_power_kept_after_handshake", res_power, held);
    end

    // Reset in the middle of a block must discard all partial state
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      samp_valid = 1'b1;
      samp_data  = DW'(gen(KIND_TONE, 100, 0, i));
      tick();
    end
    samp_valid = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    checkOutput("midreset_busy", busy, 0);
    checkOutput("midreset_res_valid", res_valid, 0);
    checkOutput("midreset_res_power", res_power, 0);
    checkOutput("midreset_sat", sat, 0);
    applyStimulus(16'h0000, KIND_TONE, 100, 0, 0, -1, lat);
    checkOutput("midreset_rerun_power", res_power, 48'd163840000);
    handshake();

    // Gapped input, a start pulse mid-block, then a long stall with start and samples in HOLD
    applyStimulus(16'h0000, KIND_TONE, 100, 0, 1, 50, lat);
    checkOutput("latency_gapped", lat, 2 * N + 2);
    for (int c = 0; c < 10; c++) begin
      start      = (c == 3);
      samp_valid = 1'b1;
      samp_data  = DW'(-2000);
      tick();
      checkOutput("hold_res_valid", res_valid, 1);
      checkOutput("hold_res_power", res_power, 48'd163840000);
    end
    start      = 1'b0;
    samp_valid = 1'b0;
    checkOutput("hold_sat", sat, 0);
    handshake();

    // Start immediately after the handshake edge
    applyStimulus(16'hC000, KIND_IMPULSE, 64, 2, 0, -1, lat);
    checkOutput("back_to_back_latency", lat, N + 3);
    checkOutput("back_to_back_power", res_power, 48'd4096);
    handshake();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
